// File: rtl/dds_spi_pkg.sv
// Shared types and constants for the DDS SPI writer: FSM state encoding and sizing defaults.
package dds_spi_pkg;

   localparam int DEF_MAX_BYTES = 9;
   localparam int BITS_PER_BYTE = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_HOLD   = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

endpackage

// File: rtl/dds_spi_clkdiv.sv
// sclk timing for the DDS SPI writer: a tick every CLK_DIV cycles while running, split into
// rise/fall strobes while shifting.
module dds_spi_clkdiv #(
   parameter int CLK_DIV = 1
) (
   input  logic DDS_clock,
   input  logic reset,
   input  logic run,
   input  logic shift,
   output logic tick,
   output logic rise,
   output logic fall
);

   localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;
   logic       phase_q, phase_d;

   assign tick = run && (cnt_q == LAST);
   assign rise = tick && shift && !phase_q;
   assign fall = tick && shift && phase_q;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (!run || tick) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end
      if (!shift) begin
         phase_d = 1'b0;
      end else if (tick) begin
         phase_d = ~phase_q;
      end
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge DDS_clock) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/dds_spi_writer.sv
// SPI write master for DDS register access: latches a request and shifts it out MSB first.
// Defining DDS_SPI_READBACK_EN adds the sdo capture path and the rd_data output.
module dds_spi_writer
   import dds_spi_pkg::*;
#(
   parameter  int MAX_BYTES = DEF_MAX_BYTES,
   parameter  int NUM_CS    = 1,
   parameter  int CLK_DIV   = 1,
   localparam int DATA_W    = MAX_BYTES * BITS_PER_BYTE,
   localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic              DDS_clock,
   input  logic              reset,
   input  logic              wr_req,
   input  logic [3:0]        wr_len,
   input  logic [CS_W-1:0]   wr_cs_sel,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              busy,
   output logic              done,
   output logic              len_err,
   output logic [NUM_CS-1:0] cs_n,
   output logic              sclk,
   output logic              sdio
`ifdef DDS_SPI_READBACK_EN
   ,
   input  logic              sdo,
   output logic [DATA_W-1:0] rd_data
`endif
);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic [6:0]          cnt_q, cnt_d;
   logic [CS_W-1:0]     cs_sel_q, cs_sel_d;
   logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
   logic                sclk_q, sclk_d;
   logic                sdio_q, sdio_d;
   logic                busy_q, busy_d;
   logic                wr_ack_q, wr_ack_d;
   logic                done_q, done_d;
   logic                len_err_q, len_err_d;

   logic req_ok, cs_low, div_run, div_shift, tick, rise, fall;

   assign req_ok = (wr_len != 4'd0) && (32'(wr_len) <= MAX_BYTES) && (32'(wr_cs_sel) < NUM_CS);
   assign cs_low = ~&cs_n_q;

   // SETUP spends its first cycle driving cs_n/sdio; the CLK_DIV wait starts once cs_n is visibly low.
   assign div_run   = ((state_q == ST_SETUP) && cs_low) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
   assign div_shift = (state_q == ST_SHIFT);

   dds_spi_clkdiv #(
      .CLK_DIV (CLK_DIV)
   ) u_clkdiv (
      .DDS_clock (DDS_clock),
      .reset     (reset),
      .run       (div_run),
      .shift     (div_shift),
      .tick      (tick),
      .rise      (rise),
      .fall      (fall)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      cs_sel_d  = cs_sel_q;
      cs_n_d    = cs_n_q;
      sclk_d    = sclk_q;
      sdio_d    = sdio_q;
      busy_d    = busy_q;
      wr_ack_d  = 1'b0;
      done_d    = 1'b0;
      len_err_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (wr_req && req_ok) begin
               shift_d  = wr_data;
               cnt_d    = {wr_len, 3'b000};
               cs_sel_d = wr_cs_sel;
               wr_ack_d = 1'b1;
               busy_d   = 1'b1;
               state_d  = ST_SETUP;
            end else if (wr_req) begin
               len_err_d = 1'b1;
            end
         end
         ST_SETUP: begin
            if (!cs_low) begin
               cs_n_d = ~(NUM_CS'(1) << cs_sel_q);
               sdio_d = shift_q[DATA_W-1];
            end else if (tick) begin
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (rise) begin
               sclk_d = 1'b1;
               cnt_d  = cnt_q - 7'd1;
            end else if (fall) begin
               sclk_d = 1'b0;
               if (cnt_q == 7'd0) begin
                  sdio_d  = 1'b0;
                  state_d = ST_HOLD;
               end else begin
                  shift_d = shift_q << 1;
                  sdio_d  = shift_q[DATA_W-2];
               end
            end
         end
         ST_HOLD: begin
            if (tick) begin
               cs_n_d  = '1;
               state_d = ST_FINISH;
            end
         end
         ST_FINISH: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge DDS_clock) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         cs_sel_q  <= '0;
         cs_n_q    <= '1;
         sclk_q    <= 1'b0;
         sdio_q    <= 1'b0;
         busy_q    <= 1'b0;
         wr_ack_q  <= 1'b0;
         done_q    <= 1'b0;
         len_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         cs_sel_q  <= cs_sel_d;
         cs_n_q    <= cs_n_d;
         sclk_q    <= sclk_d;
         sdio_q    <= sdio_d;
         busy_q    <= busy_d;
         wr_ack_q  <= wr_ack_d;
         done_q    <= done_d;
         len_err_q <= len_err_d;
      end
   end

   assign wr_ack  = wr_ack_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign len_err = len_err_q;
   assign cs_n    = cs_n_q;
   assign sclk    = sclk_q;
   assign sdio    = sdio_q;

`ifdef DDS_SPI_READBACK_EN
   logic [DATA_W-1:0] rx_q, rx_d, rd_data_q, rd_data_d;

   // Capture alongside the sclk rising edge; rd_data is published as FINISH hands over to done.
   always_comb begin
      rx_d      = rx_q;
      rd_data_d = rd_data_q;
      if (state_q == ST_IDLE) begin
         rx_d = '0;
      end else if (rise) begin
         rx_d = {rx_q[DATA_W-2:0], sdo};
      end
      if (state_q == ST_FINISH) begin
         rd_data_d = rx_q;
      end
   end

   always_ff @(posedge DDS_clock) begin
      if (reset) begin
         rx_q      <= '0;
         rd_data_q <= '0;
      end else begin
         rx_q      <= rx_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_dds_spi_writer.sv
// Scoreboard bench for dds_spi_writer: the driver queues expected outcomes, a negedge monitor
// reassembles each serial transfer and compares it with the queued expectation.
module tb_dds_spi_writer;

   localparam int MAX_BYTES = 9;
   localparam int NUM_CS    = 3;
   localparam int CLK_DIV   = 2;
   localparam int W         = MAX_BYTES * 8;
   localparam int CS_W      = 2;

   logic              DDS_clock = 1'b0;
   logic              reset     = 1'b1;
   logic              wr_req    = 1'b0;
   logic [3:0]        wr_len    = '0;
   logic [CS_W-1:0]   wr_cs_sel = '0;
   logic [W-1:0]      wr_data   = '0;
   logic              wr_ack, busy, done, len_err, sclk, sdio;
   logic [NUM_CS-1:0] cs_n;
`ifdef DDS_SPI_READBACK_EN
   logic              sdo = 1'b0;
   logic [W-1:0]      rd_data;
`endif

   always #5 DDS_clock = ~DDS_clock;

   dds_spi_writer #(
      .MAX_BYTES (MAX_BYTES),
      .NUM_CS    (NUM_CS),
      .CLK_DIV   (CLK_DIV)
   ) dut (
      .DDS_clock (DDS_clock),
      .reset     (reset),
      .wr_req    (wr_req),
      .wr_len    (wr_len),
      .wr_cs_sel (wr_cs_sel),
      .wr_data   (wr_data),
      .wr_ack    (wr_ack),
      .busy      (busy),
      .done      (done),
      .len_err   (len_err),
      .cs_n      (cs_n),
      .sclk      (sclk),
      .sdio      (sdio)
`ifdef DDS_SPI_READBACK_EN
      ,
      .sdo       (sdo),
      .rd_data   (rd_data)
`endif
   );

   typedef struct {
      bit           is_ack;
      int           len;
      int           cs;
      logic [W-1:0] data;
      bit           b2b;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_err_exp = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference model: acceptance rule and latency straight from the transfer definition.
   function automatic bit ref_ok(input int len, input int cs);
      return (len >= 1) && (len <= MAX_BYTES) && (cs < NUM_CS);
   endfunction

   function automatic int ref_latency(input int len);
      return CLK_DIV * (2 * len * 8 + 2) + 2;
   endfunction

   function automatic logic [W-1:0] rand_data();
      return W'({$urandom(), $urandom(), $urandom()});
   endfunction

   // ---------------- monitor / scoreboard ----------------
   int           cyc = 0, ack_cyc = 0, done_cyc = -100;
   bit           inflight = 0;
   exp_t         cur, e;
   logic [127:0] rx_bits;
   int           nbits = 0, bad_rise = 0, idle_bad = 0, n_err_seen = 0;
   logic [NUM_CS-1:0] low_mask;
   logic         prev_sclk = 1'b0;

   always @(negedge DDS_clock) begin
      cyc++;
      if (reset) begin
         inflight = 0;
      end else begin
         if (inflight) low_mask |= ~cs_n;
         else if (cs_n !== '1 || sclk !== 1'b0) idle_bad++;
         if (sclk && !prev_sclk) begin
            rx_bits = {rx_bits[126:0], sdio};
            nbits++;
            if (!inflight || cs_n !== ~(NUM_CS'(1) << cur.cs)) bad_rise++;
         end
         if (len_err) n_err_seen++;
         if (wr_ack || len_err) begin
            if (exp_q.size() == 0) begin
               check("unexpected ack/len_err", {wr_ack, len_err}, 2'b00);
            end else begin
               e = exp_q.pop_front();
               check("ack/len_err kind", {wr_ack, len_err}, e.is_ack ? 2'b10 : 2'b01);
               if (e.is_ack) begin
                  if (e.b2b) check("back-to-back ack gap", 128'(cyc - done_cyc), 128'd1);
                  cur      = e;
                  inflight = 1;
                  ack_cyc  = cyc;
                  rx_bits  = '0;
                  nbits    = 0;
                  low_mask = '0;
                  bad_rise = 0;
               end else begin
                  check("busy on reject", busy, 1'b0);
               end
            end
         end
         if (done) begin
            if (!inflight) begin
               check("done without transfer", done, 1'b0);
            end else begin
               check("latency", 128'(cyc - ack_cyc), 128'(ref_latency(cur.len)));
               check("bit count", 128'(nbits), 128'(cur.len * 8));
               check("serial data", rx_bits, 128'(cur.data) >> (W - cur.len * 8));
               check("cs_n low mask", 128'(low_mask), 128'(NUM_CS'(1) << cur.cs));
               check("sclk rise outside selected cs", 128'(bad_rise), 128'd0);
               check("idle levels at done", {sclk, sdio, busy}, 3'b000);
`ifdef DDS_SPI_READBACK_EN
               if (cur.len == 2) check("readback rd_data", rd_data[15:0], 16'h1234);
`endif
               inflight = 0;
               done_cyc = cyc;
            end
         end
      end
      prev_sclk = sclk;
   end

`ifdef DDS_SPI_READBACK_EN
   int          rb_idx = 0;
   logic [15:0] rb_pat = 16'h1234;
   logic        rb_prev = 1'b0;

   // Device model: presents the next readback bit after each sclk rising edge.
   always @(negedge DDS_clock) begin
      if (wr_ack) rb_idx = 0;
      else if (sclk && !rb_prev) rb_idx++;
      rb_prev = sclk;
      sdo = (rb_idx < 16) ? rb_pat[15-rb_idx] : 1'b0;
   end
`endif

   // ---------------- driver ----------------
   task automatic step();
      @(posedge DDS_clock);
      #1;
   endtask

   task automatic drive(input int len, input int cs, input logic [W-1:0] data);
      wr_len    = 4'(len);
      wr_cs_sel = CS_W'(cs);
      wr_data   = data;
   endtask

   task automatic push(input int len, input int cs, input logic [W-1:0] data, input bit b2b);
      exp_t x;
      x.is_ack = ref_ok(len, cs);
      x.len    = len;
      x.cs     = cs;
      x.data   = data;
      x.b2b    = b2b;
      if (!x.is_ack) n_err_exp++;
      exp_q.push_back(x);
   endtask

   // Waits for done while scrambling inputs; stray requests stop well before FINISH.
   task automatic wait_done(input int len);
      int lat = ref_latency(len);
      bit seen = 0;
      for (int i = 0; i < lat + 8 && !seen; i++) begin
         step();
         if (done) begin
            seen = 1;
         end else begin
            drive($urandom_range(0, 15), $urandom_range(0, 3), rand_data());
            wr_req = (i < lat - 6) ? 1'($urandom_range(0, 1)) : 1'b0;
         end
      end
      wr_req = 1'b0;
      check("done seen in time", seen, 1'b1);
   endtask

   task automatic xfer(input int len, input int cs, input logic [W-1:0] data);
      push(len, cs, data, 0);
      drive(len, cs, data);
      wr_req = 1'b1;
      step();
      wr_req = 1'b0;
      if (ref_ok(len, cs)) wait_done(len);
      else repeat (2) step();
   endtask

   initial begin
      logic [W-1:0] d1, d2;
      int len, cs, rises;
      bit seen;
      logic prev;

      repeat (3) step();
      check("reset cs_n", cs_n, {NUM_CS{1'b1}});
      check("reset sclk/sdio", {sclk, sdio}, 2'b00);
      check("reset busy/wr_ack/done/len_err", {busy, wr_ack, done, len_err}, 4'b0000);
      reset = 1'b0;
      step();

      d1 = rand_data();
      d1[W-1 -: 8] = 8'hA5;
      xfer(1, 0, d1);
      xfer(9, 0, rand_data());
      xfer(0, 0, rand_data());
      xfer(10, 1, rand_data());
      xfer(2, 3, rand_data());

      // Back-to-back: request held high across both transfers.
      d1 = rand_data();
      d2 = rand_data();
      push(3, 0, d1, 0);
      push(2, 1, d2, 1);
      drive(3, 0, d1);
      wr_req = 1'b1;
      step();
      drive(2, 1, d2);
      seen = 0;
      for (int i = 0; i < ref_latency(3) + 8 && !seen; i++) begin
         step();
         if (done) seen = 1;
      end
      check("first back-to-back done seen", seen, 1'b1);
      step();
      wr_req = 1'b0;
      wait_done(2);

      xfer(2, 1, rand_data());

      // Reset after five bits have been clocked out.
      push(4, 2, rand_data(), 0);
      drive(4, 2, exp_q[exp_q.size()-1].data);
      wr_req = 1'b1;
      step();
      wr_req = 1'b0;
      rises = 0;
      prev  = 1'b0;
      for (int i = 0; i < 200 && rises < 5; i++) begin
         step();
         if (sclk && !prev) rises++;
         prev = sclk;
      end
      check("sclk rises before reset", 128'(rises), 128'd5);
      reset = 1'b1;
      step();
      check("abort cs_n", cs_n, {NUM_CS{1'b1}});
      check("abort sclk/busy/done", {sclk, busy, done}, 3'b000);
      reset = 1'b0;
      repeat (CLK_DIV * 80) step();

      for (int n = 0; n < 14; n++) begin
         len = ($urandom_range(0, 3) != 0) ? $urandom_range(1, MAX_BYTES) : $urandom_range(0, 15);
         cs  = ($urandom_range(0, 4) != 0) ? $urandom_range(0, NUM_CS - 1) : 3;
         xfer(len, cs, rand_data());
      end

      repeat (10) step();
      check("pending expectations", 128'(exp_q.size()), 128'd0);
      check("len_err pulse count", 128'(n_err_seen), 128'(n_err_exp));
      check("cs_n/sclk activity while idle", 128'(idle_bad), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: run did not complete, compared=%0d", n_cmp);
      $fatal(1);
   end

endmodule

// File: doc/dds_spi_writer.md
DDS_SPI_WRITER -- requirements
Module: dds_spi_writer

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 9, giving the maximum transfer length in bytes (instruction byte plus payload).
REQ-002 SHALL have parameter NUM_CS, default 1, giving the number of independent active-low chip selects.
REQ-003 SHALL have parameter CLK_DIV, default 1, range 1..255, giving the sclk half-period in DDS_clock cycles.
REQ-004 SHALL have port DDS_clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port wr_req, input, 1 bit: transfer request, level-sampled.
REQ-007 SHALL have port wr_len, input, 4 bits: byte count, valid values 1..MAX_BYTES.
REQ-008 SHALL have port wr_cs_sel, input, clog2(NUM_CS) bits (minimum 1): target chip select.
REQ-009 SHALL have port wr_data, input, MAX_BYTES*8 bits: MSB-aligned data; the first bit sent is bit MAX_BYTES*8-1.
REQ-010 SHALL have port wr_ack, output, 1 bit: one-cycle pulse on request acceptance.
REQ-011 SHALL have port busy, output, 1 bit: high from acceptance until return to IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse at transfer end.
REQ-013 SHALL have port len_err, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-014 SHALL have port cs_n, output, NUM_CS bits: active-low chip selects.
REQ-015 SHALL have port sclk, output, 1 bit: serial clock; idle level is low.
REQ-016 SHALL have port sdio, output, 1 bit: serial data out.

Function
REQ-017 SHALL implement the states IDLE, SETUP, SHIFT, HOLD and FINISH.
REQ-018 In IDLE, when wr_req=1 and wr_len is valid, SHALL latch wr_data, wr_len and wr_cs_sel, pulse wr_ack, set busy and go to SETUP.
REQ-019 In IDLE, when wr_req=1 and wr_len is 0 or greater than MAX_BYTES, SHALL pulse len_err, not pulse wr_ack, and stay in IDLE.
REQ-020 In SETUP, SHALL drive the selected cs_n bit low, present the first bit on sdio, wait CLK_DIV cycles, then go to SHIFT.
REQ-021 In SHIFT, SHALL toggle sclk every CLK_DIV cycles; sdio changes only on the falling edge of sclk, and the device samples on the rising edge.
REQ-022 SHALL send exactly wr_len*8 bits; a 7-bit counter loaded with {wr_len,3'b000} decrements after each rising edge of sclk.
REQ-023 After the last falling edge of sclk, SHALL go to HOLD, keep cs_n low for CLK_DIV cycles, then deassert all cs_n bits and go to FINISH.
REQ-024 In FINISH, SHALL pulse done, clear busy and return to IDLE; a new request can be accepted on the following cycle.
REQ-025 Total latency from the wr_ack cycle to the done cycle SHALL be CLK_DIV*(2*wr_len*8+2)+2 cycles.
REQ-026 SHALL ignore wr_req while busy, and SHALL NOT alter the latched data if the inputs change mid-transfer.
REQ-027 A wr_cs_sel value of NUM_CS or greater SHALL be rejected with len_err, in the same way as an invalid length.
REQ-028 After the last bit, SHALL drive sdio to 0 and hold sclk low.

Reset
REQ-029 reset SHALL take priority over all other inputs and abort any transfer in progress within one cycle.
REQ-030 Reset values: state=IDLE, cs_n all 1, sclk=0, sdio=0, busy=0, wr_ack=0, done=0, len_err=0, counters and shift register 0.
REQ-031 A transfer aborted by reset SHALL NOT produce a done pulse.

Configuration
REQ-032 Macro DDS_SPI_READBACK_EN: when defined, SHALL add an input sdo (1 bit) and an output rd_data (MAX_BYTES*8 bits).
REQ-033 With DDS_SPI_READBACK_EN, SHALL shift sdo into the LSB of a receive register on each rising edge of sclk, and SHALL update rd_data at the done pulse; rd_data holds its value otherwise and resets to 0.
REQ-034 Without DDS_SPI_READBACK_EN, the sdo and rd_data ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 The shared package dds_spi_pkg SHALL hold the state encoding typedef, the default MAX_BYTES, and a BITS_PER_BYTE=8 constant.
REQ-036 The sclk divider SHALL be a separate sub-module, dds_spi_clkdiv, which outputs rise and fall strobes.

Verification
REQ-037 Scenario, single byte: CLK_DIV=1, wr_len=1, data MSB byte 8'hA5, cs 0 -> sdio carries 1,0,1,0,0,1,0,1 on 8 rising edges of sclk, and done arrives 20 cycles after wr_ack.
REQ-038 Scenario, full length: wr_len=9, CLK_DIV=2 -> 72 rising edges of sclk, cs_n low throughout, latency 2*(146)+2=294 cycles.
REQ-039 Scenario, invalid length: wr_len=0, then wr_len=10 -> len_err pulses twice, with no wr_ack, no cs_n activity and busy staying 0.
REQ-040 Scenario, mid-transfer reset: reset asserted after 5 bits -> next cycle cs_n all 1, sclk 0, busy 0, and no done pulse.
REQ-041 Scenario, back-to-back: wr_req held high across two transfers on cs 0 and then cs 1 (NUM_CS=2) -> the second wr_ack comes 1 cycle after the first done, and only the selected cs_n bit goes low.
REQ-042 Scenario, readback (macro defined): sdo driven with 16'h1234 during a 2-byte transfer -> rd_data low 16 bits equal 16'h1234 at done.
